cpu_bus_arbiter: RTL



---
 rtl/cpu_bus_arbiter.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/cpu_bus_arbiter.sv
// CPU-to-system-bus bridge: serialises per-channel CPU requests onto one stb/ack master port.
// Define CPU_BUS_ARB_RR_EN for round-robin arbitration; fixed priority (lowest index) otherwise.
module cpu_bus_arbiter #(
    parameter int unsigned NCH     = 2,
    parameter int unsigned AW      = 32,
    parameter int unsigned DW      = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              bus_clk_i,
    input  logic              bus_rst_i,
    input  logic [NCH-1:0]    ch_en_i,
    input  logic [NCH-1:0]    ch_wr_i,
    input  logic [NCH*AW-1:0] ch_adr_i,
    input  logic [NCH*DW-1:0] ch_dat_i,
    output logic [NCH*DW-1:0] ch_dat_o,
    output logic [NCH-1:0]    ch_err_o,
    input  logic              err_clr_i,
    output logic              bus_stb_o,
    output logic              bus_we_o,
    output logic [AW-1:0]     bus_adr_o,
    output logic [DW-1:0]     bus_dat_o,
    input  logic [DW-1:0]     bus_dat_i,
    input  logic              bus_ack_i,
    output logic              cpu_clk_o,
    output logic              cpu_rst_o,
    output logic              cpu_pause_o
);

    localparam int unsigned GW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int unsigned CW = $clog2(TIMEOUT);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic {
        ST_IDLE,
        ST_BUSY
    } state_e;

    state_e              state_q, state_d;
    logic [NCH-1:0]      done_q, done_d;
    logic [NCH-1:0]      err_q, err_d;
    logic [NCH*DW-1:0]   rdat_q, rdat_d;
    logic [GW-1:0]       grant_q, grant_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                stb_q, stb_d;
    logic                we_q, we_d;
    logic [AW-1:0]       adr_q, adr_d;
    logic [DW-1:0]       wdat_q, wdat_d;
    logic [NCH-1:0]      pend;
    logic [GW-1:0]       winner;

    assign pend        = ch_en_i & ~done_q;
    assign cpu_pause_o = |pend;
    assign cpu_clk_o   = bus_clk_i;
    assign cpu_rst_o   = bus_rst_i;

    assign bus_stb_o = stb_q;
    assign bus_we_o  = we_q;
    assign bus_adr_o = adr_q;
    assign bus_dat_o = wdat_q;
    assign ch_dat_o  = rdat_q;
    assign ch_err_o  = err_q;

`ifdef CPU_BUS_ARB_RR_EN
    logic [GW-1:0] last_q, last_d;

    // Search starts just after the previous winner; descending loop leaves the nearest one.
    always_comb begin
        winner = '0;
        for (int k = int'(NCH); k >= 1; k--) begin
            if (pend[(int'(last_q) + k) % int'(NCH)]) begin
                winner = GW'((int'(last_q) + k) % int'(NCH));
            end
        end
    end

    always_comb begin
        last_d = last_q;
        if (state_q == ST_IDLE && (|pend)) begin
            last_d = winner;
        end
    end

    always_ff @(posedge bus_clk_i) begin
        if (bus_rst_i) begin
            last_q <= GW'(NCH - 1);
        end else begin
            last_q <= last_d;
        end
    end
`else
    // Fixed priority: lowest pending index wins.
    always_comb begin
        winner = '0;
        for (int i = int'(NCH) - 1; i >= 0; i--) begin
            if (pend[i]) begin
                winner = GW'(i);
            end
        end
    end
`endif

    always_comb begin
        state_d = state_q;
        done_d  = done_q;
        err_d   = err_q;
        rdat_d  = rdat_q;
        grant_d = grant_q;
        cnt_d   = cnt_q;
        stb_d   = stb_q;
        we_d    = we_q;
        adr_d   = adr_q;
        wdat_d  = wdat_q;

        // Clear first so a same-cycle timeout set takes precedence.
        if (err_clr_i) begin
            err_d = '0;
        end

        case (state_q)
            ST_IDLE: begin
                if (|pend) begin
                    grant_d = winner;
                    adr_d   = ch_adr_i[int'(winner) * int'(AW) +: AW];
                    wdat_d  = ch_dat_i[int'(winner) * int'(DW) +: DW];
                    we_d    = ch_wr_i[winner];
                    stb_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (bus_ack_i) begin
                    done_d[grant_q] = 1'b1;
                    if (!we_q) begin
                        rdat_d[int'(grant_q) * int'(DW) +: DW] = bus_dat_i;
                    end
                    stb_d   = 1'b0;
                    we_d    = 1'b0;
                    state_d = ST_IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    done_d[grant_q] = 1'b1;
                    err_d[grant_q]  = 1'b1;
                    if (!we_q) begin
                        rdat_d[int'(grant_q) * int'(DW) +: DW] = DW'(0);
                    end
                    stb_d   = 1'b0;
                    we_d    = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // CPU advances whenever nothing is pending; the next step starts clean.
        if (!cpu_pause_o) begin
            done_d = '0;
        end
    end

    always_ff @(posedge bus_clk_i) begin
        if (bus_rst_i) begin
            state_q <= ST_IDLE;
            done_q  <= '0;
            err_q   <= '0;
            rdat_q  <= '0;
            grant_q <= '0;
            cnt_q   <= '0;
            stb_q   <= 1'b0;
            we_q    <= 1'b0;
            adr_q   <= '0;
            wdat_q  <= '0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
            err_q   <= err_d;
            rdat_q  <= rdat_d;
            grant_q <= grant_d;
            cnt_q   <= cnt_d;
            stb_q   <= stb_d;
            we_q    <= we_d;
            adr_q   <= adr_d;
            wdat_q  <= wdat_d;
        end
    end

endmodule
